// File: rtl/seq_pkg.sv
// Shared types for the datapath sequencer: opcodes, FSM states, ALU op codes and decoded controls.
package seq_pkg;

    typedef enum logic [3:0] {
        OP_R    = 4'h0,
        OP_LW   = 4'h4,
        OP_SW   = 4'h5,
        OP_ADDI = 4'h6,
        OP_LI   = 4'h7,
        OP_BEQ  = 4'h8
    } opcode_e;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_e;

    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SUB = 4'h1;
    localparam logic [3:0] ALU_BEQ = 4'hA;

    typedef struct packed {
        logic        legal;
        logic        writes_reg;
        logic        uses_mem;
        logic        is_store;
        logic        is_branch;
        logic        ovf_class;
        logic        alu_src1;
        logic        alu_src2;
        logic        mem_to_reg;
        logic [3:0]  alu_op;
        logic [2:0]  rd_addr1;
        logic [2:0]  rd_addr2;
        logic [2:0]  wr_addr;
        logic [15:0] imm;
    } ctrl_t;

    // Only add/subtract can raise a meaningful overflow.
    function automatic logic is_add_class(input logic [3:0] op);
        return (op == ALU_ADD) || (op == ALU_SUB);
    endfunction

endpackage

// File: rtl/seq_decoder.sv
// Combinational instruction decoder: 16-bit IR word -> ctrl_t bundle.
module seq_decoder
    import seq_pkg::*;
#(
    parameter int IMM_W = 6
) (
    input  logic [15:0] ir_i,
    output ctrl_t       ctrl_o
);

    logic [15:0] imm_ext;

    assign imm_ext = {{(16-IMM_W){ir_i[IMM_W-1]}}, ir_i[IMM_W-1:0]};

    always_comb begin
        ctrl_o          = '0;
        ctrl_o.legal    = 1'b1;
        ctrl_o.rd_addr1 = ir_i[11:9];
        ctrl_o.rd_addr2 = ir_i[8:6];
        ctrl_o.wr_addr  = ir_i[8:6];
        ctrl_o.imm      = imm_ext;
        ctrl_o.alu_op   = ALU_ADD;
        case (ir_i[15:12])
            OP_R: begin
                ctrl_o.alu_op     = {1'b0, ir_i[2:0]};
                ctrl_o.wr_addr    = ir_i[5:3];
                ctrl_o.writes_reg = 1'b1;
                ctrl_o.ovf_class  = is_add_class({1'b0, ir_i[2:0]});
            end
            OP_ADDI: begin
                ctrl_o.alu_src2   = 1'b1;
                ctrl_o.writes_reg = 1'b1;
                ctrl_o.ovf_class  = 1'b1;
            end
            OP_LI: begin
                ctrl_o.alu_src1   = 1'b1;
                ctrl_o.alu_src2   = 1'b1;
                ctrl_o.writes_reg = 1'b1;
            end
            OP_LW: begin
                ctrl_o.alu_src2   = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.writes_reg = 1'b1;
                ctrl_o.uses_mem   = 1'b1;
            end
            OP_SW: begin
                ctrl_o.alu_src2 = 1'b1;
                ctrl_o.uses_mem = 1'b1;
                ctrl_o.is_store = 1'b1;
            end
            OP_BEQ: begin
                ctrl_o.alu_op    = ALU_BEQ;
                ctrl_o.is_branch = 1'b1;
            end
            default: begin
                // Undefined opcode: drive nothing onto the datapath.
                ctrl_o = '0;
            end
        endcase
    end

endmodule

// File: rtl/datapath_sequencer.sv
// Multi-cycle control FSM for the regfile/ALU/data-memory datapath.
// Build option SEQ_OVF_TRAP_EN: ALU overflow on an add-class op halts the sequencer.
module datapath_sequencer
    import seq_pkg::*;
#(
    parameter int IMM_W = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    input  logic [15:0] instr,
    output logic        instr_ready,
    input  logic        alu_ovf,
    input  logic        alu_take_branch,
    output logic [2:0]  rd_addr1,
    output logic [2:0]  rd_addr2,
    output logic [2:0]  wr_addr,
    output logic [15:0] imm_out,
    output logic [3:0]  alu_op,
    output logic        alu_src1,
    output logic        alu_src2,
    output logic        mem_write,
    output logic        mem_to_reg,
    output logic        reg_write,
    output logic        done,
    output logic        branch_taken,
    output logic        illegal,
    output logic        ovf_ctrl,
    output state_e      state_dbg
);

`ifdef SEQ_OVF_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif

    // Handshake: an instruction transfers on a rising edge where instr_valid
    // and instr_ready are both high; instr_ready is only ever high in IDLE.

    state_e      state_q;
    logic [15:0] ir_q, ir_d;
    ctrl_t       ctrl_q, ctrl_d;
    logic        ready_q;
    logic        reg_write_q;
    logic        mem_write_q;
    logic        done_q;
    logic        illegal_q;
    logic        ovf_pulse_q;
    logic        halt_q;
    logic        accept;
    logic        ovf_hit;

    assign accept  = (state_q == S_IDLE) && instr_valid && ready_q;
    assign ir_d    = accept ? instr : ir_q;
    assign ovf_hit = alu_ovf && ctrl_q.ovf_class;

    // Decode the word being captured so controls are registered on entry to DECODE.
    seq_decoder #(.IMM_W(IMM_W)) u_decoder (
        .ir_i   (ir_d),
        .ctrl_o (ctrl_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            ir_q        <= '0;
            ctrl_q      <= '0;
            ready_q     <= 1'b0;
            reg_write_q <= 1'b0;
            mem_write_q <= 1'b0;
            done_q      <= 1'b0;
            illegal_q   <= 1'b0;
            ovf_pulse_q <= 1'b0;
            halt_q      <= 1'b0;
        end else begin
            ready_q     <= 1'b0;
            reg_write_q <= 1'b0;
            mem_write_q <= 1'b0;
            done_q      <= 1'b0;
            illegal_q   <= 1'b0;
            ovf_pulse_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        ir_q      <= ir_d;
                        ctrl_q    <= ctrl_d;
                        state_q   <= S_DECODE;
                        done_q    <= !ctrl_d.legal;
                        illegal_q <= !ctrl_d.legal;
                    end else begin
                        ready_q <= !halt_q;
                    end
                end
                S_DECODE: begin
                    if (!ctrl_q.legal) begin
                        state_q <= S_IDLE;
                        ready_q <= !halt_q;
                    end else begin
                        state_q <= S_EXEC;
                        done_q  <= ctrl_q.is_branch;
                    end
                end
                S_EXEC: begin
                    if (ctrl_q.is_branch) begin
                        state_q <= S_IDLE;
                        ready_q <= !halt_q;
                    end else if (ctrl_q.uses_mem) begin
                        state_q     <= S_MEM;
                        mem_write_q <= ctrl_q.is_store;
                        done_q      <= ctrl_q.is_store;
                    end else begin
                        // Overflow is judged here, on the EXEC -> WB edge.
                        state_q     <= S_WB;
                        done_q      <= 1'b1;
                        reg_write_q <= ctrl_q.writes_reg && !(TRAP_EN && ovf_hit);
                        ovf_pulse_q <= ovf_hit;
                        halt_q      <= halt_q || (TRAP_EN && ovf_hit);
                    end
                end
                S_MEM: begin
                    if (ctrl_q.is_store) begin
                        state_q <= S_IDLE;
                        ready_q <= !halt_q;
                    end else begin
                        state_q     <= S_WB;
                        reg_write_q <= 1'b1;
                        done_q      <= 1'b1;
                    end
                end
                S_WB: begin
                    state_q <= S_IDLE;
                    ready_q <= !halt_q;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Write strobes are masked by reset so an abandoned instruction never commits.
    assign reg_write    = reg_write_q && !reset;
    assign mem_write    = mem_write_q && !reset;
    assign instr_ready  = ready_q;
    assign done         = done_q;
    assign illegal      = illegal_q;
    assign branch_taken = done_q && ctrl_q.is_branch && alu_take_branch;
    assign ovf_ctrl     = ovf_pulse_q || halt_q;
    assign rd_addr1     = ctrl_q.rd_addr1;
    assign rd_addr2     = ctrl_q.rd_addr2;
    assign wr_addr      = ctrl_q.wr_addr;
    assign imm_out      = ctrl_q.imm;
    assign alu_op       = ctrl_q.alu_op;
    assign alu_src1     = ctrl_q.alu_src1;
    assign alu_src2     = ctrl_q.alu_src2;
    assign mem_to_reg   = ctrl_q.mem_to_reg;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Self-checking bench for datapath_sequencer: vector table, directed corners, random stream.
module tb_datapath_sequencer;
    import seq_pkg::*;

`ifdef SEQ_OVF_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;
    logic        alu_ovf;
    logic        alu_take_branch;
    logic [2:0]  rd_addr1, rd_addr2, wr_addr;
    logic [15:0] imm_out;
    logic [3:0]  alu_op;
    logic        alu_src1, alu_src2, mem_write, mem_to_reg, reg_write;
    logic        done, branch_taken, illegal, ovf_ctrl;
    state_e      state_dbg;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    datapath_sequencer dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .alu_ovf(alu_ovf), .alu_take_branch(alu_take_branch),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .wr_addr(wr_addr), .imm_out(imm_out),
        .alu_op(alu_op), .alu_src1(alu_src1), .alu_src2(alu_src2), .mem_write(mem_write),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .done(done),
        .branch_taken(branch_taken), .illegal(illegal), .ovf_ctrl(ovf_ctrl),
        .state_dbg(state_dbg)
    );

    // Small datapath around the sequencer so data results can be checked end to end.
    logic [15:0] regs [8];
    logic [15:0] dmem [16];
    logic [15:0] alu_a, alu_b, alu_res;

    always_comb begin
        alu_a   = alu_src1 ? 16'h0000 : regs[rd_addr1];
        alu_b   = alu_src2 ? imm_out : regs[rd_addr2];
        alu_res = (alu_op == 4'h1) ? alu_a - alu_b : alu_a + alu_b;
    end

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) regs[i] <= 16'h0000;
            for (int i = 0; i < 16; i++) dmem[i] <= 16'h0000;
        end else begin
            if (reg_write) regs[wr_addr] <= mem_to_reg ? dmem[alu_res[3:0]] : alu_res;
            if (mem_write) dmem[alu_res[3:0]] <= regs[rd_addr2];
        end
    end

    typedef struct {
        logic [15:0] instr;
        bit          ovf;
        bit          tkb;
        int          cyc;
        bit          rw;
        bit          mw;
        bit          bt;
        bit          ill;
        bit          ov;
        logic [2:0]  wr;
        logic [3:0]  aop;
        bit          s1;
        bit          s2;
        bit          m2r;
        logic [15:0] imm;
    } vec_t;

    // Reference model: per-opcode cycle count, final-cycle strobes and control values.
    function automatic vec_t model(input logic [15:0] ins, input bit ovf, input bit tkb);
        vec_t v;
        v = '{ins, ovf, tkb, 1, 0, 0, 0, 0, 0, 3'd0, 4'd0, 0, 0, 0, 16'd0};
        v.imm = ins[5] ? (16'hFFC0 | {10'd0, ins[5:0]}) : {10'd0, ins[5:0]};
        v.wr  = ins[8:6];
        case (ins[15:12])
            4'h0: begin v.cyc = 3; v.rw = 1; v.aop = {1'b0, ins[2:0]}; v.wr = ins[5:3];
                        v.ov = ovf && (ins[2:0] < 3'd2); end
            4'h4: begin v.cyc = 4; v.rw = 1; v.s2 = 1; v.m2r = 1; end
            4'h5: begin v.cyc = 3; v.mw = 1; v.s2 = 1; end
            4'h6: begin v.cyc = 3; v.rw = 1; v.s2 = 1; v.ov = ovf; end
            4'h7: begin v.cyc = 3; v.rw = 1; v.s1 = 1; v.s2 = 1; end
            4'h8: begin v.cyc = 2; v.aop = 4'hA; v.bt = tkb; end
            default: v.ill = 1;
        endcase
        if (TRAP && v.ov) v.rw = 0;
        return v;
    endfunction

    function automatic logic [63:0] stat_now();
        return {57'd0, instr_ready, reg_write, mem_write, done, illegal, branch_taken, ovf_ctrl};
    endfunction

    function automatic logic [63:0] ctrl_now();
        return {32'd0, rd_addr1, rd_addr2, wr_addr, imm_out, alu_op, alu_src1, alu_src2, mem_to_reg};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; instr_valid = 1'b1; instr = 16'h0258;
        alu_ovf = 1'b1; alu_take_branch = 1'b1;
        repeat (3) begin
            @(negedge clk); #1;
            check("reset_stat", stat_now(), 64'd0);
            check("reset_ctrl", ctrl_now(), 64'd0);
        end
        check("reset_state", 64'(state_dbg), 64'(S_IDLE));
        reset = 1'b0;
        @(negedge clk); #1;
        check("post_reset_ready", stat_now(), 64'h40);
        instr_valid = 1'b0;
    endtask

    // Starts just after a negedge; returns in the IDLE cycle after the instruction.
    task automatic run_vec(input vec_t v, input string tag);
        int w;
        logic [63:0] exp_stat;
        instr = v.instr; instr_valid = 1'b1;
        w = 0;
        while (!instr_ready && w < 20) begin
            @(negedge clk); w++;
        end
        if (w == 20) begin
            check($sformatf("%s_ready_timeout_%h", tag, v.instr), 64'(instr_ready), 64'd1);
            instr_valid = 1'b0;
            return;
        end
        @(negedge clk);
        instr = 16'($urandom);
        for (int k = 0; k < v.cyc; k++) begin
            alu_ovf         = (k == 1) ? v.ovf : 1'($urandom_range(0, 1));
            alu_take_branch = (k == 1) ? v.tkb : 1'($urandom_range(0, 1));
            if (k == v.cyc - 1) instr_valid = 1'b0;
            #1;
            exp_stat = 64'd0;
            if (k == v.cyc - 1)
                exp_stat = {57'd0, 1'b0, v.rw, v.mw, 1'b1, v.ill, v.bt, v.ov};
            check($sformatf("%s_stat_%h_k%0d", tag, v.instr, k), stat_now(), exp_stat);
            if (!v.ill)
                check($sformatf("%s_ctrl_%h_k%0d", tag, v.instr, k), ctrl_now(),
                      {32'd0, v.instr[11:9], v.instr[8:6], v.wr, v.imm, v.aop, v.s1, v.s2, v.m2r});
            @(negedge clk);
        end
        #1;
        check($sformatf("%s_ready_after_%h", tag, v.instr), 64'(instr_ready),
              64'(!(TRAP && v.ov)));
    endtask

    vec_t        tbl [12];
    vec_t        vo;
    logic [3:0]  opc;
    logic [15:0] ins;
    bit          ovf_r;

    initial begin
        //           instr     ovf tkb cyc rw mw bt il ov wr    aop    s1 s2 m2r imm
        tbl[0]  = '{16'h7045, 0, 0, 3, 1, 0, 0, 0, 0, 3'd1, 4'h0, 1, 1, 0, 16'h0005};
        tbl[1]  = '{16'h0258, 0, 0, 3, 1, 0, 0, 0, 0, 3'd3, 4'h0, 0, 0, 0, 16'h0018};
        tbl[2]  = '{16'h5042, 0, 0, 3, 0, 1, 0, 0, 0, 3'd1, 4'h0, 0, 1, 0, 16'h0002};
        tbl[3]  = '{16'h4082, 0, 0, 4, 1, 0, 0, 0, 0, 3'd2, 4'h0, 0, 1, 1, 16'h0002};
        tbl[4]  = '{16'h8243, 0, 1, 2, 0, 0, 1, 0, 0, 3'd1, 4'hA, 0, 0, 0, 16'h0003};
        tbl[5]  = '{16'h8243, 0, 0, 2, 0, 0, 0, 0, 0, 3'd1, 4'hA, 0, 0, 0, 16'h0003};
        tbl[6]  = '{16'hF123, 0, 0, 1, 0, 0, 0, 1, 0, 3'd0, 4'h0, 0, 0, 0, 16'h0000};
        tbl[7]  = '{16'h633E, 0, 0, 3, 1, 0, 0, 0, 0, 3'd4, 4'h0, 0, 1, 0, 16'hFFFE};
        tbl[8]  = '{16'h02E9, 0, 0, 3, 1, 0, 0, 0, 0, 3'd5, 4'h1, 0, 0, 0, 16'hFFE9};
        tbl[9]  = '{16'h4082, 1, 0, 4, 1, 0, 0, 0, 0, 3'd2, 4'h0, 0, 1, 1, 16'h0002};
        tbl[10] = '{16'h0007, 1, 0, 3, 1, 0, 0, 0, 0, 3'd0, 4'h7, 0, 0, 0, 16'h0007};
        tbl[11] = '{16'h8243, 1, 0, 2, 0, 0, 0, 0, 0, 3'd1, 4'hA, 0, 0, 0, 16'h0003};

        do_reset();

        for (int i = 0; i < 12; i++) begin
            run_vec(tbl[i], "tbl");
            if (i == 3) begin
                check("r3_add_result", 64'(regs[3]), 64'h000A);
                check("r2_lw_result", 64'(regs[2]), 64'h0005);
            end
        end
        check("r4_addi_result", 64'(regs[4]), 64'h0003);
        check("r5_sub_result", 64'(regs[5]), 64'hFFFB);

        // Reset arriving in the WB cycle must kill the write-back.
        alu_ovf = 1'b0; alu_take_branch = 1'b0;
        instr = 16'h0258; instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        check("midrst_wb_pre", 64'(reg_write), 64'd1);
        reset = 1'b1; #1;
        check("midrst_wb_strobes", {62'd0, reg_write, mem_write}, 64'd0);
        @(negedge clk); #1;
        check("midrst_stat", stat_now(), 64'd0);
        check("midrst_state", 64'(state_dbg), 64'(S_IDLE));
        reset = 1'b0;
        @(negedge clk); #1;
        check("midrst_ready", 64'(instr_ready), 64'd1);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 6))
                0: opc = 4'h0;
                1: opc = 4'h4;
                2: opc = 4'h5;
                3: opc = 4'h6;
                4: opc = 4'h7;
                5: opc = 4'h8;
                default: opc = 4'($urandom_range(9, 15));
            endcase
            ins   = {opc, 12'($urandom)};
            ovf_r = TRAP ? 1'b0 : 1'($urandom_range(0, 1));
            run_vec(model(ins, ovf_r, 1'($urandom_range(0, 1))), "rand");
        end

        // ADD r6,r1,r1 with overflow: pulse and write, or trap and halt.
        vo = '{16'h0270, 1, 0, 3, !TRAP, 0, 0, 0, 1, 3'd6, 4'h0, 0, 0, 0, 16'hFFF0};
        run_vec(vo, "ovf");
        repeat (3) begin
            @(negedge clk); #1;
            check("ovf_after", {62'd0, instr_ready, ovf_ctrl}, {62'd0, !TRAP, TRAP});
        end

        do_reset();
        check("final_ovf_clear", 64'(ovf_ctrl), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
